// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared command encoding and modulo pointer helpers for the LIFO stack
//
// Contents:
//   cmd_t    2-bit command: NOP / PUSH / POP / GET
//   mod_inc  pointer increment wrapping DEPTH-1 -> 0
//   mod_dec  pointer decrement wrapping 0 -> DEPTH-1
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_t;

    // Explicit wrap so non-power-of-two depths never rely on bit truncation.
    function automatic int unsigned mod_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned mod_dec(input int unsigned ptr, input int unsigned depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH register array, one sync write port, one comb read port
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear of every entry
//   we     in   write enable
//   waddr  in   write address (< DEPTH)
//   wdata  in   write data
//   raddr  in   read address (< DEPTH)
//   rdata  out  combinational read data
module stack_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised LIFO stack with status flags, full policy and error pulse
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RESET    in   asynchronous active-low reset
//   COMMAND  in   00 NOP, 01 PUSH, 10 POP, 11 GET
//   INDEX    in   GET depth offset, 0 = top of stack
//   I_DATA   in   PUSH data
//   O_DATA   out  registered read data (POP/GET)
//   O_VALID  out  one-cycle pulse, O_DATA updated by a successful POP/GET
//   ERR      out  one-cycle pulse, command rejected
//   FULL     out  COUNT == DEPTH
//   EMPTY    out  COUNT == 0
//   COUNT    out  number of valid entries
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter bit WRAP  = 1'b1,
    localparam int IW   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IW-1:0]    INDEX,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic             ERR,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CW-1:0]    COUNT
);

    cmd_t             cmd;
    logic [IW-1:0]    top_q, top_n;
    logic [CW-1:0]    count_q, count_n;
    logic [WIDTH-1:0] odata_q, odata_n;
    logic             ovalid_q, ovalid_n;
    logic             err_q, err_n;

    logic             we;
    logic [IW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    logic [IW:0]      top_ext;
    logic [IW:0]      rd_off;
    logic [IW:0]      raddr_ext;
    logic [IW-1:0]    top_inc;
    logic [IW-1:0]    top_dec;
    logic             is_full;
    logic             is_empty;
    logic             get_ok;

    assign cmd = cmd_t'(COMMAND);

    assign top_inc  = IW'(mod_inc(32'(top_q), DEPTH));
    assign top_dec  = IW'(mod_dec(32'(top_q), DEPTH));
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign get_ok   = (32'(INDEX) < 32'(count_q));

    // Shared read path: POP reads TOP-1, GET reads TOP-1-INDEX, both mod DEPTH.
    // The extra bit keeps TOP+DEPTH from overflowing; the result is < DEPTH
    // whenever the access is legal, so the final slice drops only a zero bit.
    always_comb begin
        top_ext = {1'b0, top_q};
        rd_off  = (IW + 1)'(1);
        if (cmd == CMD_GET) begin
            rd_off = {1'b0, INDEX} + (IW + 1)'(1);
        end
        if (top_ext >= rd_off) begin
            raddr_ext = top_ext - rd_off;
        end else begin
            raddr_ext = top_ext + (IW + 1)'(DEPTH) - rd_off;
        end
        raddr = raddr_ext[IW-1:0];
    end

    always_comb begin
        top_n    = top_q;
        count_n  = count_q;
        odata_n  = odata_q;
        ovalid_n = 1'b0;
        err_n    = 1'b0;
        we       = 1'b0;
        case (cmd)
            CMD_NOP: begin
            end
            CMD_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    top_n   = top_inc;
                    count_n = count_q + CW'(1);
                end else if (WRAP) begin
                    // Full ring: writing at TOP overwrites the oldest entry.
                    we    = 1'b1;
                    top_n = top_inc;
                end else begin
                    err_n = 1'b1;
                end
            end
            CMD_POP: begin
                if (!is_empty) begin
                    odata_n  = rdata;
                    ovalid_n = 1'b1;
                    top_n    = top_dec;
                    count_n  = count_q - CW'(1);
                end else begin
                    err_n = 1'b1;
                end
            end
            CMD_GET: begin
                if (get_ok) begin
                    odata_n  = rdata;
                    ovalid_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            top_q    <= '0;
            count_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            top_q    <= top_n;
            count_q  <= count_n;
            odata_q  <= odata_n;
            ovalid_q <= ovalid_n;
            err_q    <= err_n;
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_regfile (
        .clk   (CLK),
        .rst_n (RESET),
        .we    (we),
        .waddr (top_q),
        .wdata (I_DATA),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign O_DATA  = odata_q;
    assign O_VALID = ovalid_q;
    assign ERR     = err_q;
    assign COUNT   = count_q;
    assign FULL    = is_full;
    assign EMPTY   = is_empty;

endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - randomized self-checking bench for stack_param (WRAP=1 and WRAP=0 side by side)
module tb_stack_param;
    import stack_pkg::*;

    localparam int W  = 4;
    localparam int D  = 5;
    localparam int IW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [IW-1:0] idx = '0;
    logic [W-1:0]  din = '0;

    logic [W-1:0]  od_w, od_r;
    logic          ov_w, ov_r, er_w, er_r, fu_w, fu_r, em_w, em_r;
    logic [CW-1:0] ct_w, ct_r;

    int checks = 0;
    int errors = 0;

    // Reference: index 0 = wrap-policy stack, index 1 = reject-policy stack.
    // Each queue holds entries oldest-first; the back is the top of stack.
    int mq [2][$];
    int m_od [2];
    int m_ov [2];
    int m_er [2];

    always #5 clk = ~clk;

    stack_param #(.WIDTH(W), .DEPTH(D), .WRAP(1'b1)) dut_w (
        .CLK(clk), .RESET(rst_n), .COMMAND(cmd), .INDEX(idx), .I_DATA(din),
        .O_DATA(od_w), .O_VALID(ov_w), .ERR(er_w), .FULL(fu_w), .EMPTY(em_w), .COUNT(ct_w)
    );

    stack_param #(.WIDTH(W), .DEPTH(D), .WRAP(1'b0)) dut_r (
        .CLK(clk), .RESET(rst_n), .COMMAND(cmd), .INDEX(idx), .I_DATA(din),
        .O_DATA(od_r), .O_VALID(ov_r), .ERR(er_r), .FULL(fu_r), .EMPTY(em_r), .COUNT(ct_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            m_od[d] = 0;
            m_ov[d] = 0;
            m_er[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input int c, input int i, input int data);
        int n;
        n = mq[d].size();
        m_ov[d] = 0;
        m_er[d] = 0;
        case (c)
            1: begin
                if (n < D) begin
                    mq[d].push_back(data);
                end else if (d == 0) begin
                    void'(mq[d].pop_front());
                    mq[d].push_back(data);
                end else begin
                    m_er[d] = 1;
                end
            end
            2: begin
                if (n > 0) begin
                    m_od[d] = mq[d].pop_back();
                    m_ov[d] = 1;
                end else begin
                    m_er[d] = 1;
                end
            end
            3: begin
                if (i < n) begin
                    m_od[d] = mq[d][n - 1 - i];
                    m_ov[d] = 1;
                end else begin
                    m_er[d] = 1;
                end
            end
            default: begin
            end
        endcase
    endtask

    task automatic check_one(input string tag, input int d, input logic [W-1:0] od, input logic ov,
                             input logic er, input logic fu, input logic em, input logic [CW-1:0] ct);
        int n;
        string p;
        n = mq[d].size();
        p = $sformatf("%s/%s", tag, (d == 0) ? "wrap" : "rej");
        check({p, " odata"}, 32'(od), 32'(m_od[d]));
        check({p, " ovalid"}, 32'(ov), 32'(m_ov[d]));
        check({p, " err"}, 32'(er), 32'(m_er[d]));
        check({p, " count"}, 32'(ct), 32'(n));
        check({p, " full"}, 32'(fu), 32'(n == D));
        check({p, " empty"}, 32'(em), 32'(n == 0));
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, od_w, ov_w, er_w, fu_w, em_w, ct_w);
        check_one(tag, 1, od_r, ov_r, er_r, fu_r, em_r, ct_r);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string tag, input int c, input int i, input int data);
        cmd = c[1:0];
        idx = i[IW-1:0];
        din = data[W-1:0];
        @(posedge clk);
        model_step(0, c, i, data);
        model_step(1, c, i, data);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cmd = 2'b00;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic push then GET by depth
        for (int v = 1; v <= 3; v++) step("push123", 1, 0, v);
        for (int i = 0; i < 3; i++) step("get012", 3, i, 0);

        // Overfill: wrap overwrites oldest, reject raises ERR
        do_reset();
        for (int v = 1; v <= 7; v++) step("push1to7", 1, 0, v);
        for (int i = 0; i < 5; i++) step("getfull", 3, i, 0);
        step("nop_after_get", 0, 0, 0);

        // Pop down past empty
        do_reset();
        step("push9", 1, 0, 9);
        step("push10", 1, 0, 10);
        step("pop1", 2, 0, 0);
        step("pop2", 2, 0, 0);
        step("pop_empty", 2, 0, 0);

        // Out-of-range GET with COUNT=2, including INDEX beyond DEPTH
        step("push_a", 1, 0, 4);
        step("push_b", 1, 0, 6);
        step("get_top", 3, 0, 0);
        step("get_idx2", 3, 2, 0);
        step("get_idx7", 3, 7, 0);

        // Asynchronous reset mid-cycle during a PUSH
        do_reset();
        for (int v = 1; v <= 3; v++) step("push_pre_rst", 1, 0, v + 10);
        cmd = 2'b01;
        din = 4'hf;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("get_after_rst", 3, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            int c;
            c = int'($urandom_range(0, 9));
            c = (c < 4) ? 1 : (c < 6) ? 2 : (c < 9) ? 3 : 0;
            step("rand", c, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised LIFO stack; successor to the fixed 4-bit, depth-5 structural stack.
- Uses the same 2-bit command set: NOP/PUSH/POP/GET.
- Replaces the bidirectional data bus with separate input and registered output ports.
- Adds occupancy/status flags, a selectable full-stack policy (overwrite-oldest or reject) and an error pulse for illegal operations.
- Used as a generic operand/return-address stack in datapath exercises.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 5, number of entries (>=2; need not be a power of two).
- WRAP, 1, full-stack policy: 1 = PUSH on full overwrites the oldest entry; 0 = PUSH on full is rejected.
- Derived: IW = max(1, $clog2(DEPTH)) is the INDEX width; CW = $clog2(DEPTH+1) is the COUNT width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- COMMAND  in  2  00 NOP, 01 PUSH, 10 POP, 11 GET; sampled on the rising edge.
- INDEX  in  IW  GET depth offset; 0 = top of stack.
- I_DATA  in  WIDTH  PUSH data.
- O_DATA  out  WIDTH  registered read data (POP/GET).
- O_VALID  out  1  one-cycle pulse: O_DATA was updated by a successful POP/GET.
- ERR  out  1  one-cycle pulse: the command was rejected.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  CW  number of valid entries.

Behaviour:
- Reset (RESET low, asynchronous assert, synchronous-to-CLK release):
  - all memory entries, TOP pointer, COUNT, O_DATA, O_VALID and ERR go to 0; EMPTY=1, FULL=0.
  - Asserting reset mid-operation discards the command in flight.
- TOP points to the next free slot. All pointer arithmetic is explicit modulo DEPTH: increment from DEPTH-1 goes to 0, decrement from 0 goes to DEPTH-1. Bit truncation must not be relied on.
- All outputs are registered. A command sampled at edge n is reflected in every output after edge n (latency 1). O_VALID and ERR are high for exactly that one cycle.
- NOP:
  - O_VALID=0, ERR=0; O_DATA holds; no state change.
- PUSH with COUNT<DEPTH:
  - mem[TOP]=I_DATA, TOP+1, COUNT+1; O_VALID=0, ERR=0; O_DATA holds.
- PUSH with COUNT==DEPTH:
  - WRAP=1: mem[TOP]=I_DATA, TOP+1, COUNT stays DEPTH. The oldest entry is lost. ERR=0.
  - WRAP=0: no write, no pointer change, ERR=1.
- POP with COUNT>0:
  - O_DATA=mem[TOP-1], TOP-1, COUNT-1, O_VALID=1.
  - The vacated entry is not cleared.
- POP with COUNT==0:
  - ERR=1, O_VALID=0, O_DATA holds, no state change.
- GET with INDEX<COUNT:
  - O_DATA=mem[(TOP-1-INDEX) mod DEPTH], O_VALID=1; no state change.
- GET with INDEX>=COUNT (including INDEX>=DEPTH when DEPTH is not a power of two):
  - ERR=1, O_VALID=0, O_DATA holds.
- The command encoding is exhaustive; there are no undefined commands.
- FULL, EMPTY and COUNT are derived from the registered COUNT, so they update in the same cycle as the data effects.

Decomposition:
- Package stack_pkg holds:
  - cmd_t enum (CMD_NOP=2'b00, CMD_PUSH=2'b01, CMD_POP=2'b10, CMD_GET=2'b11);
  - a modulo increment/decrement function parametrised by DEPTH.
- One sub-module, stack_regfile: DEPTH x WIDTH register array with one synchronous write port, one combinational read port and async active-low clear.
- stack_param contains the pointer/count control, command decode and output registers.

Test Plan (all with WIDTH=4, DEPTH=5):
- Reset, then PUSH 1,2,3 -> COUNT=3, EMPTY=0; then GET INDEX=0,1,2 -> O_DATA 3,2,1, each with O_VALID=1, ERR=0.
- With WRAP=1: PUSH 1..7 -> COUNT=5, FULL=1, no ERR; then GET INDEX=0..4 -> 7,6,5,4,3.
- With WRAP=0: PUSH 1..6 -> sixth PUSH gives ERR=1 for one cycle; then GET INDEX=0 -> 5, COUNT stays 5.
- PUSH 9,10 then POP,POP,POP -> O_DATA 10 then 9 (O_VALID=1); third POP gives ERR=1, O_DATA holds 9, EMPTY=1.
- With COUNT=2: GET INDEX=2 and GET INDEX=7 -> ERR=1, O_VALID=0, O_DATA unchanged.
- Push 3 words, assert RESET low asynchronously mid-cycle during a PUSH -> all outputs 0 immediately, EMPTY=1; after release, GET INDEX=0 -> ERR=1.
